// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative multiply/divide unit for the EX stage. Owns the
//                architectural HI/LO registers, runs MULT/MULTU/DIV/DIVU one
//                bit per cycle while stalling the pipeline, and services
//                MTHI/MTLO writes. HI/LO feed the EX result mux for MFHI/MFLO.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [5:0]       func_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0]    c_func_mthi   = 6'h11;
    localparam logic [5:0]    c_func_mtlo   = 6'h13;
    localparam logic [CW-1:0] c_last_count  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_count_one   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic               r_is_div;
    logic               r_neg_q;     // negate quotient / product
    logic               r_neg_r;     // negate remainder (dividend sign)
    logic               r_dbz;       // divide by zero captured at start
    logic [WIDTH-1:0]   r_opa;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_rs_raw;    // raw dividend, returned in HI on divide by zero
    logic [2*WIDTH-1:0] r_acc;       // {HI,LO} working register
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_is_md;
    logic               w_start;
    logic               w_mt_ok;
    logic               w_signed;
    logic               w_div;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Decode of the incoming instruction and start / move-to qualification.
    // Start is also gated by reset so the pipeline is never stalled while
    // the unit is held in reset.
    always_comb begin
        w_is_md  = valid_i && (func_i[5:2] == 4'b0110);
        w_start  = rst_n_i && w_is_md && (r_state == ST_IDLE) && !flush_i;
        w_mt_ok  = valid_i && (r_state == ST_IDLE) && !flush_i;
        w_signed = ~func_i[0];
        w_div    = func_i[1];
        w_rs_neg = w_signed & rs_data_i[WIDTH-1];
        w_rt_neg = w_signed & rt_data_i[WIDTH-1];
        w_rs_mag = w_rs_neg ? -rs_data_i : rs_data_i;
        w_rt_mag = w_rt_neg ? -rt_data_i : rt_data_i;
    end

    // One shift-add multiply step: add multiplicand into the upper half when
    // the current multiplier LSB is set, then shift the whole pair right.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
    end

    // One restoring-division step: shift {rem,quot} left, subtract the
    // divisor when it fits and shift the resulting quotient bit in.
    // When the subtraction is taken the true difference is below 2^WIDTH,
    // so a WIDTH-bit subtract is exact.
    always_comb begin
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_opa});
        w_sub      = w_rem_sh[WIDTH-1:0] - r_opa;
        w_div_next = {(w_ge ? w_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end

    // Final sign correction and the divide-by-zero override.
    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        if (r_is_div) begin
            if (r_dbz) begin
                w_res_lo = {WIDTH{1'b1}};
                w_res_hi = r_rs_raw;
            end else begin
                w_res_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_res_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end else begin
            w_res_lo = w_prod[WIDTH-1:0];
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM together with the iteration datapath and HI/LO ownership.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_opa    <= '0;
            r_rs_raw <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_is_div <= w_div;
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_dbz    <= w_div && (rt_data_i == '0);
                        r_rs_raw <= rs_data_i;
                        r_opa    <= w_div ? w_rt_mag : w_rs_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_rs_mag : w_rt_mag)};
                        r_count  <= c_last_count;
                        r_state  <= ST_RUN;
                    end else if (w_mt_ok && (func_i == c_func_mthi)) begin
                        r_hi <= rs_data_i;
                    end else if (w_mt_ok && (func_i == c_func_mtlo)) begin
                        r_lo <= rs_data_i;
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (r_count == '0) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_count <= r_count - c_count_one;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    if (!flush_i) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall holds the pipeline from the start cycle through the last iteration.
    assign stall_o = w_start || (r_state == ST_RUN);
    assign done_o  = r_done;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Self-checking bench for ex_muldiv with a result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    ex_muldiv #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .valid_i   (valid),
        .func_i    (func),
        .rs_data_i (rs),
        .rt_data_i (rt),
        .flush_i   (flush),
        .stall_o   (stall),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {HI,LO}
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] res;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (f)
            6'h18: res = sa * sb;
            6'h19: res = {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            6'h1B: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else begin
                    uq = a / b;
                    ur = a % b;
                    res = {ur, uq};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation
    initial begin
        logic [63:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_done: hi=%h lo=%h, required no result", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    if ({hi, lo} !== e) begin
                        bad++;
                        $display("FAIL sb_result: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Issue one mul/div, hold the instruction through FIN, check latency and done
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int cnt;
        @(posedge clk);
        #1;
        valid = 1'b1; func = f; rs = a; rt = b;
        exp_q.push_back({eh, el});
        #1;
        cnt = 0;
        while (stall === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #2;
        end
        total++;
        if (cnt !== 33) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d, required 33", name, cnt);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_pulse: got %b, required 1", name, done);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL %s no_restart: done=%b stall=%b, required 0 0", name, done, stall);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valid = 1'b0; func = 6'h0; rs = '0; rt = '0; flush = 1'b0;
        #23;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: hi=%h lo=%h done=%b stall=%b, required 0 0 0 0", hi, lo, done, stall);
        end
    endtask

    task automatic test_multiply;
        run_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
        run_op(6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin");
    endtask

    task automatic test_divide;
        run_op(6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run_op(6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, "divu_basic");
        run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");
    endtask

    task automatic test_div_by_zero;
        run_op(6'h1B, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, "divu_zero");
        run_op(6'h1A, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_zero");
    endtask

    task automatic test_move_to;
        @(posedge clk);
        #1;
        valid = 1'b1; func = 6'h11; rs = 32'h0000AAAA;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL mthi_stall: got %b, required 0", stall);
        end
        @(posedge clk);
        #1;
        func = 6'h13; rs = 32'h00005555;
        #1;
        total++;
        if (stall !== 1'b0 || hi !== 32'h0000AAAA) begin
            bad++;
            $display("FAIL mthi_write: stall=%b hi=%h, required 0 0000aaaa", stall, hi);
        end
        @(posedge clk);
        #1;
        func = 6'h20; rs = 32'h0000DEAD;
        #1;
        total++;
        if (hi !== 32'h0000AAAA || lo !== 32'h00005555) begin
            bad++;
            $display("FAIL mtlo_write: hi=%h lo=%h, required 0000aaaa 00005555", hi, lo);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        total++;
        if (hi !== 32'h0000AAAA || lo !== 32'h00005555 || stall !== 1'b0) begin
            bad++;
            $display("FAIL unknown_funct: hi=%h lo=%h stall=%b, required 0000aaaa 00005555 0", hi, lo, stall);
        end
    endtask

    task automatic test_flush;
        logic [31:0] oh, ol;
        oh = hi; ol = lo;
        // flush in IDLE suppresses start and move-to
        @(posedge clk);
        #1;
        valid = 1'b1; func = 6'h19; rs = 32'd3; rt = 32'd5; flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_start: stall=%b, required 0", stall);
        end
        func = 6'h11; rs = 32'h12345678;
        @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b0;
        total++;
        if (hi !== oh) begin
            bad++;
            $display("FAIL flush_idle_mt: hi=%h, required %h", hi, oh);
        end
        // flush at RUN cycle 10
        valid = 1'b1; func = 6'h19; rs = 32'hFFFF; rt = 32'hFFFF;
        repeat (11) @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || hi !== oh || lo !== ol) begin
            bad++;
            $display("FAIL flush_run: stall=%b hi=%h lo=%h, required 0 %h %h", stall, hi, lo, oh, ol);
        end
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (hi !== oh || lo !== ol) begin
            bad++;
            $display("FAIL flush_hold: hi=%h lo=%h, required %h %h", hi, lo, oh, ol);
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #1;
        valid = 1'b1; func = 6'h18; rs = 32'd9; rt = 32'd9;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0; valid = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: stall=%b hi=%h lo=%h, required 0 0 0", stall, hi, lo);
        end
        #10;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_hold: stall=%b hi=%h lo=%h, required 0 0 0", stall, hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] m;
        logic [5:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom();
            b = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 1000)));
            m = model(f, a, b);
            run_op(f, a, b, m[63:32], m[31:0], "b2b_random");
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_move_to();
        test_flush();
        test_async_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered funct field and RS/RT operand data, and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and stalls the pipeline while it is busy.
- Also services MTHI/MTLO writes and supplies HI/LO to the EX result mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  the instruction in EX is an R-type.
- func_i  input  6  funct field from ID/EX.
- rs_data_i  input  32  RS operand: dividend, multiplicand or MT source.
- rt_data_i  input  32  RT operand: divisor or multiplier.
- flush_i  input  1  abort any in-flight operation.
- stall_o  output  1  hold IF/ID and ID/EX, and bubble EX/MEM.
- done_o  output  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi_o  output  32  HI register.
- lo_o  output  32  LO register.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Recognised funct codes:
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - MTHI 0x11, MTLO 0x13.
  - All other codes are ignored.
- Definition: start = valid_i & func_i in {0x18..0x1B} & state==IDLE & !flush_i.
- Reset: state=IDLE; hi_o=lo_o=0; stall_o=0 (combinational from IDLE with valid_i=0); done_o=0; counter=0.
- States:
  - IDLE: on start, latch operands and op type, take absolute values for signed ops, record result signs, counter=WIDTH-1, go to RUN.
  - RUN: one iteration per cycle. At counter==0 go to FIN; otherwise decrement the counter.
  - FIN: apply sign correction, write HI/LO, pulse done_o, then go to IDLE unconditionally.
- stall_o = start | (state==RUN).
  - Total stall is 1 + WIDTH = 33 cycles.
  - stall_o is 0 in FIN so the pipeline advances at the end of FIN.
  - valid_i/func_i still showing the same instruction during FIN are ignored, because the state is not IDLE.
  - HI/LO become visible to the following instruction (e.g. MFHI) in the cycle after FIN.
- Multiply:
  - Shift-add on 64-bit {HI,LO}.
  - Signed product = two's-complement negation of the unsigned magnitude product when the operand signs differ.
- Divide:
  - Restoring division on the magnitudes; LO=quotient, HI=remainder.
  - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - -2^31 / -1 gives LO=0x80000000, HI=0 (natural result, no trap).
- Divide by zero is detected at start and still takes the full latency. Result LO=0xFFFFFFFF, HI=rs_data_i, with no sign correction, for both DIV and DIVU.
- MTHI/MTLO:
  - Taken only when valid_i is set and state==IDLE; written at the next edge; no stall, no done_o.
  - If not IDLE, they are ignored; the pipeline is stalled anyway.
- flush_i:
  - In RUN or FIN it forces IDLE at the next edge; HI/LO are unchanged and done_o=0.
  - In IDLE it suppresses both start and MT writes.
- Asynchronous reset mid-operation forces IDLE with HI/LO=0 immediately.
- HI/LO change only in FIN, on MT writes, or on reset.

Test Plan:
- Reset then MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF → stall_o high for 33 cycles, done_o pulse, HI=0xFFFFFFFE, LO=0x00000001.
- MULT: rs=-3 (0xFFFFFFFD), rt=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV: rs=-7, rt=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIVU by zero: rs=0x1234 → LO=0xFFFFFFFF, HI=0x1234, still 33 stall cycles.
- MTHI 0xAAAA then MTLO 0x5555 on back-to-back cycles → no stall; HI=0xAAAA, LO=0x5555. An unrecognised funct (0x20) leaves both unchanged.
- Interruptions:
  - flush_i at RUN cycle 10 → IDLE next cycle, stall_o low, HI/LO keep their old values.
  - rst_n_i low mid-RUN → stall_o low and HI=LO=0 asynchronously.
  - Same instruction held into FIN → no restart.
